// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Instruction context held across a multi-cycle access.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        mem_to_reg;
        logic        reg_write;
    } op_t;

    // Halfword offsets are only ever 0 or 2 once alignment has been checked.
    function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: be_for = BE_B << lo;
            F3_H, F3_HU: be_for = BE_H << lo;
            default:     be_for = BE_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage and the memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store steering, byte enables, legality and
// alignment of the request, load lane extraction with sign/zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic        req_load_i,
    input  logic        req_store_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ok_o,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    input  logic [2:0]  rsp_funct3_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);
    logic        legal;
    logic        aligned;
    logic [31:0] shifted;

    always_comb begin
        legal = 1'b0;
        if (req_load_i) begin
            legal = req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end else if (req_store_i) begin
            legal = req_funct3_i inside {F3_B, F3_H, F3_W};
        end

        case (req_funct3_i)
            F3_H, F3_HU: aligned = ~req_addr_lo_i[0];
            F3_W:        aligned = (req_addr_lo_i == 2'b00);
            default:     aligned = 1'b1;
        endcase

        req_ok_o = legal & aligned;
        req_be_o = be_for(req_funct3_i, req_addr_lo_i);

        case (req_funct3_i)
            F3_B:    req_wdata_o = {4{req_wdata_i[7:0]}};
            F3_H:    req_wdata_o = {2{req_wdata_i[15:0]}};
            default: req_wdata_o = req_wdata_i;
        endcase
    end

    always_comb begin
        shifted = rsp_rdata_i >> {rsp_addr_lo_i, 3'b000};
        case (rsp_funct3_i)
            F3_B:    rsp_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rsp_data_o = {24'd0, shifted[7:0]};
            F3_H:    rsp_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rsp_data_o = {16'd0, shifted[15:0]};
            default: rsp_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on the dmem bus, stalls the pipe
// while an access is in flight and drives the MEM/WB pipeline register.
//
// state | meaning
// IDLE  | no access in flight; ALU results pass straight to MEM/WB
// REQ   | dmem_req asserted, bus outputs frozen until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hazard_stall,
    input  logic        EX_MEM_enable_out,
    input  logic [31:0] EX_MEM_PC,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [4:0]  EX_MEM_Rd,
    input  logic [2:0]  EX_MEM_Funct3,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemToReg,
    input  logic        EX_MEM_RegWrite,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] MEM_WB_PC,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [4:0]  MEM_WB_Rd,
    output logic        MEM_WB_MemToReg,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_enable_out
);
    localparam int unsigned      TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    op_t              op_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             fault_q, fault_d;

    logic        is_mem, issue, req_ok, start, timeout_hit;
    logic        commit_alu, commit_mem, abort;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, ld_data;

    mem_align u_align (
        .req_funct3_i  (EX_MEM_Funct3),
        .req_addr_lo_i (EX_MEM_ALUResult[1:0]),
        .req_load_i    (EX_MEM_MemRead),
        .req_store_i   (EX_MEM_MemWrite),
        .req_wdata_i   (EX_MEM_WriteData),
        .req_ok_o      (req_ok),
        .req_be_o      (al_be),
        .req_wdata_o   (al_wdata),
        .rsp_funct3_i  (op_q.funct3),
        .rsp_addr_lo_i (op_q.alu[1:0]),
        .rsp_rdata_i   (dmem.dmem_rdata),
        .rsp_data_o    (ld_data)
    );

    assign is_mem      = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign issue       = (state_q == IDLE) & EX_MEM_enable_out & ~hazard_stall & is_mem;
    assign start       = issue & req_ok;
    assign commit_alu  = (state_q == IDLE) & EX_MEM_enable_out & ~hazard_stall & ~is_mem;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ: begin
                if (dmem.dmem_gnt)  state_d = we_q ? IDLE : WAIT;
                else if (timeout_hit) state_d = IDLE;
            end
            WAIT: if (dmem.dmem_rvalid || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The stall drops in the completing cycle so upstream advances on that edge.
    always_comb begin
        mem_stall  = 1'b0;
        commit_mem = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            IDLE: mem_stall = start;
            REQ: begin
                commit_mem = dmem.dmem_gnt & we_q;
                abort      = ~dmem.dmem_gnt & timeout_hit;
                mem_stall  = ~(commit_mem | abort);
            end
            WAIT: begin
                commit_mem = dmem.dmem_rvalid;
                abort      = ~dmem.dmem_rvalid & timeout_hit;
                mem_stall  = ~(commit_mem | abort);
            end
            default: mem_stall = 1'b0;
        endcase
        fault_d = (issue & ~req_ok) | abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
            if (start) begin
                op_q.pc         <= EX_MEM_PC;
                op_q.alu        <= EX_MEM_ALUResult;
                op_q.rd         <= EX_MEM_Rd;
                op_q.funct3     <= EX_MEM_Funct3;
                op_q.mem_to_reg <= EX_MEM_MemToReg;
                op_q.reg_write  <= EX_MEM_RegWrite;
                we_q            <= ~EX_MEM_MemRead;
                wdata_q         <= al_wdata;
                be_q            <= al_be;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MEM_WB_PC         <= '0;
            MEM_WB_ReadData   <= '0;
            MEM_WB_ALUResult  <= '0;
            MEM_WB_Rd         <= '0;
            MEM_WB_MemToReg   <= 1'b0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
        end else if (commit_alu) begin
            MEM_WB_PC         <= EX_MEM_PC;
            MEM_WB_ReadData   <= '0;
            MEM_WB_ALUResult  <= EX_MEM_ALUResult;
            MEM_WB_Rd         <= EX_MEM_Rd;
            MEM_WB_MemToReg   <= EX_MEM_MemToReg;
            MEM_WB_RegWrite   <= EX_MEM_RegWrite;
            MEM_WB_enable_out <= 1'b1;
        end else if (commit_mem) begin
            MEM_WB_PC         <= op_q.pc;
            MEM_WB_ReadData   <= we_q ? 32'd0 : ld_data;
            MEM_WB_ALUResult  <= op_q.alu;
            MEM_WB_Rd         <= op_q.rd;
            MEM_WB_MemToReg   <= op_q.mem_to_reg;
            MEM_WB_RegWrite   <= op_q.reg_write;
            MEM_WB_enable_out <= 1'b1;
        end else begin
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
        end
    end

    assign mem_fault       = fault_q;
    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {op_q.alu[31:2], 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scripted bus responses, MEM/WB results checked
// through an expected-result queue, plus a short-timeout second instance.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        hazard_stall, en0, en1;
    logic [31:0] pc, alu, wd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, m2r, rw;

    mem_stage_if dm0();
    mem_stage_if dm1();

    logic        stall0, fault0, wb0_m2r, wb0_rw, wb0_en;
    logic [31:0] wb0_pc, wb0_rdata, wb0_alu;
    logic [4:0]  wb0_rd;
    logic        stall1, fault1, wb1_m2r, wb1_rw, wb1_en;
    logic [31:0] wb1_pc, wb1_rdata, wb1_alu;
    logic [4:0]  wb1_rd;

    mem_stage u0 (
        .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall),
        .EX_MEM_enable_out(en0), .EX_MEM_PC(pc), .EX_MEM_ALUResult(alu),
        .EX_MEM_WriteData(wd), .EX_MEM_Rd(rd), .EX_MEM_Funct3(f3),
        .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw), .EX_MEM_MemToReg(m2r),
        .EX_MEM_RegWrite(rw), .dmem(dm0.master), .mem_stall(stall0), .mem_fault(fault0),
        .MEM_WB_PC(wb0_pc), .MEM_WB_ReadData(wb0_rdata), .MEM_WB_ALUResult(wb0_alu),
        .MEM_WB_Rd(wb0_rd), .MEM_WB_MemToReg(wb0_m2r), .MEM_WB_RegWrite(wb0_rw),
        .MEM_WB_enable_out(wb0_en)
    );

    mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u1 (
        .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall),
        .EX_MEM_enable_out(en1), .EX_MEM_PC(pc), .EX_MEM_ALUResult(alu),
        .EX_MEM_WriteData(wd), .EX_MEM_Rd(rd), .EX_MEM_Funct3(f3),
        .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw), .EX_MEM_MemToReg(m2r),
        .EX_MEM_RegWrite(rw), .dmem(dm1.master), .mem_stall(stall1), .mem_fault(fault1),
        .MEM_WB_PC(wb1_pc), .MEM_WB_ReadData(wb1_rdata), .MEM_WB_ALUResult(wb1_alu),
        .MEM_WB_Rd(wb1_rd), .MEM_WB_MemToReg(wb1_m2r), .MEM_WB_RegWrite(wb1_rw),
        .MEM_WB_enable_out(wb1_en)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
    } wb_t;

    wb_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_alu = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic mr_i, input logic mw_i, input logic [2:0] f3_i,
                          input logic [31:0] alu_i, input logic [31:0] wd_i,
                          input logic [31:0] pc_i, input logic [4:0] rd_i,
                          input logic m2r_i, input logic rw_i);
        mr = mr_i; mw = mw_i; f3 = f3_i; alu = alu_i; wd = wd_i;
        pc = pc_i; rd = rd_i; m2r = m2r_i; rw = rw_i;
    endtask

    task automatic push(input logic [31:0] pc_i, input logic [31:0] alu_i,
                        input logic [31:0] rdata_i, input logic [4:0] rd_i,
                        input logic m2r_i, input logic rw_i);
        wb_t e;
        e.pc = pc_i; e.alu = alu_i; e.rdata = rdata_i; e.rd = rd_i; e.m2r = m2r_i; e.rw = rw_i;
        exp_q.push_back(e);
        last_alu = alu_i;
    endtask

    // Every committed MEM/WB entry of u0 must match the oldest expectation.
    always @(negedge clk) begin : mon
        wb_t e;
        if (reset_n && wb0_en) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb0_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_pc", wb0_pc, e.pc);
                chk("wb_alu", wb0_alu, e.alu);
                chk("wb_rdata", wb0_rdata, e.rdata);
                chk("wb_rd", {27'd0, wb0_rd}, {27'd0, e.rd});
                chk("wb_m2r", {31'd0, wb0_m2r}, {31'd0, e.m2r});
                chk("wb_rw", {31'd0, wb0_rw}, {31'd0, e.rw});
            end
        end
    end

    task automatic store_seq(input logic [2:0] f3_i, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] pc_i);
        set_op(1'b0, 1'b1, f3_i, a, d, pc_i, 5'd0, 1'b0, 1'b0);
        en0 = 1'b1;
        push(pc_i, a, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("st_start_stall", {31'd0, stall0}, 32'd1);
        chk("st_start_req", {31'd0, dm0.dmem_req}, 32'd0);
        tick();
        dm0.dmem_gnt = 1'b1;
        @(negedge clk);
        chk("st_req", {31'd0, dm0.dmem_req}, 32'd1);
        chk("st_we", {31'd0, dm0.dmem_we}, 32'd1);
        chk("st_addr", dm0.dmem_addr, a & 32'hFFFF_FFFC);
        chk("st_be", {28'd0, dm0.dmem_be}, {28'd0, exp_be});
        chk("st_wdata", dm0.dmem_wdata, exp_wd);
        chk("st_gnt_stall", {31'd0, stall0}, 32'd0);
        tick();
        dm0.dmem_gnt = 1'b0;
        en0 = 1'b0;
        @(negedge clk);
        chk("st_done_req", {31'd0, dm0.dmem_req}, 32'd0);
        tick();
    endtask

    // gnt in the third REQ cycle, rvalid three cycles after gnt.
    task automatic load_seq(input logic [2:0] f3_i, input logic [31:0] a, input logic [31:0] rdat,
                            input logic [31:0] exp_rd, input logic [3:0] exp_be,
                            input logic [31:0] pc_i);
        logic [6:0] gseq = 7'b0001000;
        logic [6:0] rseq = 7'b1000000;
        logic [6:0] sseq = 7'b0111111;
        logic [6:0] qseq = 7'b0001110;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                set_op(1'b1, 1'b0, f3_i, a, 32'd0, pc_i, 5'd7, 1'b1, 1'b1);
                en0 = 1'b1;
                push(pc_i, a, exp_rd, 5'd7, 1'b1, 1'b1);
            end
            dm0.dmem_gnt    = gseq[i];
            dm0.dmem_rvalid = rseq[i];
            dm0.dmem_rdata  = rseq[i] ? rdat : 32'h5A5A_5A5A;
            @(negedge clk);
            chk("ld_stall", {31'd0, stall0}, {31'd0, sseq[i]});
            chk("ld_req", {31'd0, dm0.dmem_req}, {31'd0, qseq[i]});
            if (qseq[i]) begin
                chk("ld_be", {28'd0, dm0.dmem_be}, {28'd0, exp_be});
                chk("ld_we", {31'd0, dm0.dmem_we}, 32'd0);
                chk("ld_addr", dm0.dmem_addr, a & 32'hFFFF_FFFC);
            end
            tick();
        end
        dm0.dmem_gnt    = 1'b0;
        dm0.dmem_rvalid = 1'b0;
        en0 = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic fault_seq(input logic mr_i, input logic mw_i, input logic [2:0] f3_i,
                             input logic [31:0] a);
        set_op(mr_i, mw_i, f3_i, a, 32'h1111_2222, 32'h80, 5'd9, 1'b1, 1'b1);
        en0 = 1'b1;
        @(negedge clk);
        chk("flt_stall", {31'd0, stall0}, 32'd0);
        chk("flt_req", {31'd0, dm0.dmem_req}, 32'd0);
        tick();
        en0 = 1'b0;
        @(negedge clk);
        chk("flt_pulse", {31'd0, fault0}, 32'd1);
        chk("flt_wb_en", {31'd0, wb0_en}, 32'd0);
        chk("flt_wb_rw", {31'd0, wb0_rw}, 32'd0);
        chk("flt_req2", {31'd0, dm0.dmem_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("flt_pulse_end", {31'd0, fault0}, 32'd0);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; hazard_stall = 1'b0; en0 = 1'b0; en1 = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        dm0.dmem_gnt = 1'b0; dm0.dmem_rvalid = 1'b0; dm0.dmem_rdata = 32'd0;
        dm1.dmem_gnt = 1'b0; dm1.dmem_rvalid = 1'b0; dm1.dmem_rdata = 32'd0;

        @(negedge clk);
        chk("rst_req", {31'd0, dm0.dmem_req}, 32'd0);
        chk("rst_wb_en", {31'd0, wb0_en}, 32'd0);
        chk("rst_wb_alu", wb0_alu, 32'd0);
        chk("rst_fault", {31'd0, fault0}, 32'd0);
        chk("rst_be", {28'd0, dm0.dmem_be}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // ALU op passes through with one-cycle latency, no bus activity.
        set_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'd0, 32'h10, 5'd5, 1'b0, 1'b1);
        en0 = 1'b1;
        push(32'h10, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b1);
        @(negedge clk);
        chk("alu_stall", {31'd0, stall0}, 32'd0);
        chk("alu_req", {31'd0, dm0.dmem_req}, 32'd0);
        tick();
        en0 = 1'b0;
        @(negedge clk);
        chk("alu_wb_en", {31'd0, wb0_en}, 32'd1);
        chk("alu_wb_rw", {31'd0, wb0_rw}, 32'd1);
        chk("alu_req2", {31'd0, dm0.dmem_req}, 32'd0);
        tick();

        store_seq(F3_B, 32'h103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'h20);
        store_seq(F3_H, 32'h102, 32'h1234_5678, 4'b1100, 32'h5678_5678, 32'h24);
        store_seq(F3_W, 32'h200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h28);

        load_seq(F3_B,  32'h102, 32'h00F0_0000, 32'hFFFF_FFF0, 4'b0100, 32'h30);
        load_seq(F3_BU, 32'h102, 32'h00F0_0000, 32'h0000_00F0, 4'b0100, 32'h34);
        load_seq(F3_H,  32'h102, 32'h8001_0000, 32'hFFFF_8001, 4'b1100, 32'h38);
        load_seq(F3_HU, 32'h102, 32'h8001_0000, 32'h0000_8001, 4'b1100, 32'h3C);
        load_seq(F3_W,  32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h40);

        fault_seq(1'b1, 1'b0, F3_W, 32'h0000_0006);
        fault_seq(1'b0, 1'b1, F3_H, 32'h0000_0101);
        fault_seq(1'b0, 1'b1, 3'b100, 32'h0000_0100);
        fault_seq(1'b1, 1'b0, 3'b011, 32'h0000_0100);

        // hazard_stall blocks a legal load: bubble, fields hold.
        hazard_stall = 1'b1;
        set_op(1'b1, 1'b0, F3_W, 32'h300, 32'd0, 32'h50, 5'd2, 1'b1, 1'b1);
        en0 = 1'b1;
        @(negedge clk);
        chk("hz_stall", {31'd0, stall0}, 32'd0);
        chk("hz_req", {31'd0, dm0.dmem_req}, 32'd0);
        tick();
        hazard_stall = 1'b0;
        en0 = 1'b0;
        @(negedge clk);
        chk("hz_wb_en", {31'd0, wb0_en}, 32'd0);
        chk("hz_wb_alu_hold", wb0_alu, last_alu);
        chk("hz_fault", {31'd0, fault0}, 32'd0);
        tick();

        // Short-timeout instance, gnt never comes.
        set_op(1'b1, 1'b0, F3_W, 32'h400, 32'd0, 32'h90, 5'd3, 1'b1, 1'b1);
        en1 = 1'b1;
        @(negedge clk);
        chk("to_start_stall", {31'd0, stall1}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("to_req", {31'd0, dm1.dmem_req}, 32'd1);
            chk("to_stall", {31'd0, stall1}, (i == 3) ? 32'd0 : 32'd1);
        end
        tick();
        en1 = 1'b0;
        dm1.dmem_rvalid = 1'b1;
        dm1.dmem_rdata  = 32'h1111_1111;
        @(negedge clk);
        chk("to_req_drop", {31'd0, dm1.dmem_req}, 32'd0);
        chk("to_fault", {31'd0, fault1}, 32'd1);
        chk("to_wb_en", {31'd0, wb1_en}, 32'd0);
        chk("to_stall_low", {31'd0, stall1}, 32'd0);
        tick();
        @(negedge clk);
        chk("to_fault_end", {31'd0, fault1}, 32'd0);
        chk("to_late_rvalid", {31'd0, wb1_en}, 32'd0);
        tick();
        dm1.dmem_rvalid = 1'b0;

        // Reset with u0 in WAIT and u1 in REQ.
        set_op(1'b1, 1'b0, F3_W, 32'h100, 32'd0, 32'hA0, 5'd4, 1'b1, 1'b1);
        en0 = 1'b1;
        en1 = 1'b1;
        @(negedge clk);
        tick();
        dm0.dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rw_req0", {31'd0, dm0.dmem_req}, 32'd1);
        tick();
        dm0.dmem_gnt = 1'b0;
        @(negedge clk);
        chk("rw_wait_req0", {31'd0, dm0.dmem_req}, 32'd0);
        chk("rw_req1", {31'd0, dm1.dmem_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_async_req1", {31'd0, dm1.dmem_req}, 32'd0);
        chk("rw_wb_en", {31'd0, wb0_en}, 32'd0);
        chk("rw_wb_rw", {31'd0, wb0_rw}, 32'd0);
        chk("rw_wb_pc", wb0_pc, 32'd0);
        chk("rw_wb_alu", wb0_alu, 32'd0);
        chk("rw_wb_rdata", wb0_rdata, 32'd0);
        chk("rw_wb_rd", {27'd0, wb0_rd}, 32'd0);
        chk("rw_wb_m2r", {31'd0, wb0_m2r}, 32'd0);
        chk("rw_fault", {31'd0, fault0}, 32'd0);
        chk("rw_addr", dm0.dmem_addr, 32'd0);
        chk("rw_be", {28'd0, dm0.dmem_be}, 32'd0);
        chk("rw_we", {31'd0, dm0.dmem_we}, 32'd0);
        chk("rw_wdata", dm0.dmem_wdata, 32'd0);
        chk("rw_u1_alu", wb1_alu, 32'd0);
        en0 = 1'b0;
        en1 = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        dm0.dmem_rvalid = 1'b1;
        dm0.dmem_rdata  = 32'h7777_7777;
        @(negedge clk);
        chk("rw_rv_ignored", {31'd0, wb0_en}, 32'd0);
        tick();
        dm0.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_rv_ignored2", {31'd0, wb0_en}, 32'd0);
        chk("rw_rdata_clear", wb0_rdata, 32'd0);
        chk("rw_req_idle", {31'd0, dm0.dmem_req}, 32'd0);
        tick();

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
